// File: rtl/pong_game_controller_if.sv
// Handshake/status bundle between the pong game controller and its surroundings.
// Pure wiring, no latency of its own.
// No backpressure: every input is a one-cycle pulse and every output is a level or pulse.
interface pong_game_controller_if;
    logic       frame_tick;
    logic       key_press;
    logic       p1_scored;
    logic       p2_scored;
    logic       game_startup;
    logic       game_over;
    logic       sq_shown;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       ball_launch;
    logic       ball_hold;
    logic       serve_dir;
    logic       paddles_en;

    // Environment side: produces the event pulses, observes game status.
    modport master (
        output frame_tick, key_press, p1_scored, p2_scored,
        input  game_startup, game_over, sq_shown, score_p1, score_p2,
               ball_launch, ball_hold, serve_dir, paddles_en
    );

    // Controller side: consumes the event pulses, drives game status.
    modport slave (
        input  frame_tick, key_press, p1_scored, p2_scored,
        output game_startup, game_over, sq_shown, score_p1, score_p2,
               ball_launch, ball_hold, serve_dir, paddles_en
    );
endinterface

// File: rtl/pong_game_controller.sv
// Pong game sequencer: startup menu, serve, play, point pause, game over, scoring.
// Latency: all outputs registered, one cycle after the causing input pulse.
// No backpressure: input pulses not relevant to the current state are dropped.
module pong_game_controller #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int PAUSE_FRAMES = 90,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                    clk_0,
    input  logic                    rst,
    pong_game_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } state_t;

    // Last count value before the transition fires (counter is zero on entry).
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     state, nxt_state;
    logic [7:0] cnt, nxt_cnt, cnt_inc;
    logic [7:0] blink_cnt, nxt_blink_cnt;
    logic       blink_ph, nxt_blink_ph;
    logic [3:0] score_p1_q, nxt_score_p1;
    logic [3:0] score_p2_q, nxt_score_p2;
    logic       serve_dir_q, nxt_dir;
    logic       launch_q, nxt_launch;
    logic       startup_q, nxt_startup;
    logic       over_q, nxt_over;
    logic       shown_q, nxt_shown;
    logic       hold_q, nxt_hold;
    logic       paddles_q, nxt_paddles;

    // State and all registered outputs; synchronous active-low reset.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state       <= ST_STARTUP;
            cnt         <= 8'd0;
            blink_cnt   <= 8'd0;
            blink_ph    <= 1'b0;
            score_p1_q  <= 4'd0;
            score_p2_q  <= 4'd0;
            serve_dir_q <= 1'b1;
            launch_q    <= 1'b0;
            startup_q   <= 1'b1;
            over_q      <= 1'b0;
            shown_q     <= 1'b0;
            hold_q      <= 1'b1;
            paddles_q   <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            blink_cnt   <= nxt_blink_cnt;
            blink_ph    <= nxt_blink_ph;
            score_p1_q  <= nxt_score_p1;
            score_p2_q  <= nxt_score_p2;
            serve_dir_q <= nxt_dir;
            launch_q    <= nxt_launch;
            startup_q   <= nxt_startup;
            over_q      <= nxt_over;
            shown_q     <= nxt_shown;
            hold_q      <= nxt_hold;
            paddles_q   <= nxt_paddles;
        end
    end

    // Next-state, counters, scores, and output decode of the next state.
    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_blink_cnt = blink_cnt;
        nxt_blink_ph  = blink_ph;
        nxt_score_p1  = score_p1_q;
        nxt_score_p2  = score_p2_q;
        nxt_dir       = serve_dir_q;
        nxt_launch    = 1'b0;
        cnt_inc       = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

        case (state)
            ST_STARTUP, ST_OVER: begin
                if (bus.key_press) begin
                    nxt_state     = ST_SERVE;
                    nxt_score_p1  = 4'd0;
                    nxt_score_p2  = 4'd0;
                    nxt_dir       = 1'b1;
                    nxt_cnt       = 8'd0;
                    nxt_blink_cnt = 8'd0;
                    nxt_blink_ph  = 1'b0;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick) begin
                    if (cnt >= SERVE_LAST) begin
                        nxt_state  = ST_PLAY;
                        nxt_launch = 1'b1;
                    end else begin
                        nxt_cnt = cnt_inc;
                    end
                    // Blink phase flips every BLINK_FRAMES ticks.
                    if (blink_cnt >= BLINK_LAST) begin
                        nxt_blink_cnt = 8'd0;
                        nxt_blink_ph  = ~blink_ph;
                    end else begin
                        nxt_blink_cnt = blink_cnt + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                // Player 1 has priority when both score in the same cycle.
                if (bus.p1_scored) begin
                    if (score_p1_q < WIN) nxt_score_p1 = score_p1_q + 4'd1;
                    nxt_dir   = 1'b1;
                    nxt_state = ST_POINT;
                    nxt_cnt   = 8'd0;
                end else if (bus.p2_scored) begin
                    if (score_p2_q < WIN) nxt_score_p2 = score_p2_q + 4'd1;
                    nxt_dir   = 1'b0;
                    nxt_state = ST_POINT;
                    nxt_cnt   = 8'd0;
                end
            end
            ST_POINT: begin
                if (bus.frame_tick) begin
                    if (cnt >= PAUSE_LAST) begin
                        nxt_cnt = 8'd0;
                        if (score_p1_q == WIN || score_p2_q == WIN) begin
                            nxt_state = ST_OVER;
                        end else begin
                            nxt_state     = ST_SERVE;
                            nxt_blink_cnt = 8'd0;
                            nxt_blink_ph  = 1'b0;
                        end
                    end else begin
                        nxt_cnt = cnt_inc;
                    end
                end
            end
            default: begin
                nxt_state = ST_STARTUP;
            end
        endcase

        nxt_startup = (nxt_state == ST_STARTUP);
        nxt_over    = (nxt_state == ST_OVER);
        nxt_hold    = (nxt_state != ST_PLAY);
        nxt_paddles = (nxt_state == ST_SERVE) || (nxt_state == ST_PLAY) ||
                      (nxt_state == ST_POINT);
        nxt_shown   = (nxt_state == ST_PLAY) ||
                      ((nxt_state == ST_SERVE) && !nxt_blink_ph);
    end

    assign bus.game_startup = startup_q;
    assign bus.game_over    = over_q;
    assign bus.sq_shown     = shown_q;
    assign bus.score_p1     = score_p1_q;
    assign bus.score_p2     = score_p2_q;
    assign bus.ball_launch  = launch_q;
    assign bus.ball_hold    = hold_q;
    assign bus.serve_dir    = serve_dir_q;
    assign bus.paddles_en   = paddles_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for the pong game controller with default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Status vector order: {startup, over, shown, launch, hold, paddles, dir}.
module tb_pong_game_controller;

    logic clk_0 = 1'b0;
    logic rst   = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pong_game_controller_if bus ();

    pong_game_controller #(
        .WIN_SCORE    (11),
        .SERVE_FRAMES (60),
        .PAUSE_FRAMES (90),
        .BLINK_FRAMES (8)
    ) dut (
        .clk_0 (clk_0),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_0 = ~clk_0;

    localparam logic [6:0] ST_RESET  = 7'b1000101;
    localparam logic [6:0] SERVE_D1  = 7'b0010111;
    localparam logic [6:0] SERVE_D0  = 7'b0010110;
    localparam logic [6:0] LAUNCH_D1 = 7'b0011011;
    localparam logic [6:0] LAUNCH_D0 = 7'b0011010;
    localparam logic [6:0] PLAY_D1   = 7'b0010011;
    localparam logic [6:0] POINT_D1  = 7'b0000111;
    localparam logic [6:0] POINT_D0  = 7'b0000110;
    localparam logic [6:0] OVER_D1   = 7'b0100101;

    function automatic logic [6:0] status();
        return {bus.game_startup, bus.game_over, bus.sq_shown, bus.ball_launch,
                bus.ball_hold, bus.paddles_en, bus.serve_dir};
    endfunction

    task automatic pulse(input logic k, input logic t, input logic s1, input logic s2);
        @(negedge clk_0);
        bus.key_press  = k;
        bus.frame_tick = t;
        bus.p1_scored  = s1;
        bus.p2_scored  = s2;
        @(negedge clk_0);
        bus.key_press  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.p1_scored  = 1'b0;
        bus.p2_scored  = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_0);
        rst = 1'b0;
        @(negedge clk_0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        bus.key_press = 1'b1;
        bus.p1_scored = 1'b1;
        repeat (2) @(negedge clk_0);
        rst = 1'b1;
        bus.key_press = 1'b0;
        bus.p1_scored = 1'b0;
        checks++;
        if (status() !== ST_RESET) begin
            errors++;
            $display("FAIL reset_status: got %b want %b", status(), ST_RESET);
        end
        checks++;
        if ({bus.score_p1, bus.score_p2} !== 8'h00) begin
            errors++;
            $display("FAIL reset_scores: got %0d:%0d want 0:0", bus.score_p1, bus.score_p2);
        end
        @(negedge clk_0);
        checks++;
        if (status() !== ST_RESET) begin
            errors++;
            $display("FAIL reset_pulse_discard: got %b want %b", status(), ST_RESET);
        end
    endtask

    task automatic test_serve_launch();
        logic exp_shown;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (status() !== SERVE_D1) begin
            errors++;
            $display("FAIL serve_entry: got %b want %b", status(), SERVE_D1);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({bus.score_p1, bus.score_p2} !== 8'h00 || status() !== SERVE_D1) begin
            errors++;
            $display("FAIL serve_scored_ignored: got %0d:%0d %b want 0:0 %b",
                     bus.score_p1, bus.score_p2, status(), SERVE_D1);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (status() !== SERVE_D1) begin
            errors++;
            $display("FAIL serve_key_ignored: got %b want %b", status(), SERVE_D1);
        end
        for (int k = 1; k < 60; k++) begin
            ticks(1);
            exp_shown = (((k / 8) % 2) == 0);
            checks++;
            if ({bus.sq_shown, bus.ball_launch, bus.ball_hold} !== {exp_shown, 2'b01}) begin
                errors++;
                $display("FAIL serve_blink_tick%0d: got shown=%b launch=%b hold=%b want %b 0 1",
                         k, bus.sq_shown, bus.ball_launch, bus.ball_hold, exp_shown);
            end
        end
        ticks(1);
        checks++;
        if (status() !== LAUNCH_D1) begin
            errors++;
            $display("FAIL launch_pulse: got %b want %b", status(), LAUNCH_D1);
        end
        @(negedge clk_0);
        checks++;
        if (status() !== PLAY_D1) begin
            errors++;
            $display("FAIL launch_single: got %b want %b", status(), PLAY_D1);
        end
    endtask

    task automatic test_p2_point();
        // Tick coincident with POINT entry must not count.
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({bus.score_p1, bus.score_p2} !== 8'h01 || status() !== POINT_D0) begin
            errors++;
            $display("FAIL p2_point: got %0d:%0d %b want 0:1 %b",
                     bus.score_p1, bus.score_p2, status(), POINT_D0);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(89);
        checks++;
        if (status() !== POINT_D0) begin
            errors++;
            $display("FAIL point_hold89: got %b want %b", status(), POINT_D0);
        end
        ticks(1);
        checks++;
        if (status() !== SERVE_D0) begin
            errors++;
            $display("FAIL point_to_serve: got %b want %b", status(), SERVE_D0);
        end
        ticks(59);
        checks++;
        if (bus.ball_launch !== 1'b0 || bus.ball_hold !== 1'b1) begin
            errors++;
            $display("FAIL reserve_no_launch: got launch=%b hold=%b want 0 1",
                     bus.ball_launch, bus.ball_hold);
        end
        ticks(1);
        checks++;
        if (status() !== LAUNCH_D0 || {bus.score_p1, bus.score_p2} !== 8'h01) begin
            errors++;
            $display("FAIL reserve_launch: got %b %0d:%0d want %b 0:1",
                     status(), bus.score_p1, bus.score_p2, LAUNCH_D0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(60);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({bus.score_p1, bus.score_p2} !== 8'h10 || status() !== POINT_D1) begin
            errors++;
            $display("FAIL simultaneous: got %0d:%0d %b want 1:0 %b",
                     bus.score_p1, bus.score_p2, status(), POINT_D1);
        end
    endtask

    task automatic test_game_over();
        for (int i = 2; i <= 10; i++) begin
            ticks(90);
            ticks(60);
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (bus.score_p1 !== 4'd10 || bus.score_p2 !== 4'd0) begin
            errors++;
            $display("FAIL score_ten: got %0d:%0d want 10:0", bus.score_p1, bus.score_p2);
        end
        ticks(90);
        ticks(60);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.score_p1 !== 4'd11 || status() !== POINT_D1) begin
            errors++;
            $display("FAIL score_win: got %0d %b want 11 %b", bus.score_p1, status(), POINT_D1);
        end
        ticks(89);
        checks++;
        if (status() !== POINT_D1) begin
            errors++;
            $display("FAIL win_pause89: got %b want %b", status(), POINT_D1);
        end
        ticks(1);
        checks++;
        if (status() !== OVER_D1) begin
            errors++;
            $display("FAIL game_over: got %b want %b", status(), OVER_D1);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        ticks(5);
        checks++;
        if ({bus.score_p1, bus.score_p2} !== 8'hB0 || status() !== OVER_D1) begin
            errors++;
            $display("FAIL over_hold: got %0d:%0d %b want 11:0 %b",
                     bus.score_p1, bus.score_p2, status(), OVER_D1);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.score_p1, bus.score_p2} !== 8'h00 || status() !== SERVE_D1) begin
            errors++;
            $display("FAIL over_restart: got %0d:%0d %b want 0:0 %b",
                     bus.score_p1, bus.score_p2, status(), SERVE_D1);
        end
    endtask

    task automatic test_reset_mid_point();
        for (int r = 0; r < 7; r++) begin
            ticks(60);
            pulse(1'b0, 1'b0, (r % 2) == 0, (r % 2) == 1);
            ticks(90);
        end
        ticks(60);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(40);
        checks++;
        if ({bus.score_p1, bus.score_p2} !== 8'h53 || status() !== POINT_D1) begin
            errors++;
            $display("FAIL mid_point_setup: got %0d:%0d %b want 5:3 %b",
                     bus.score_p1, bus.score_p2, status(), POINT_D1);
        end
        @(negedge clk_0);
        rst = 1'b0;
        bus.p2_scored  = 1'b1;
        bus.key_press  = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk_0);
        rst = 1'b1;
        bus.p2_scored  = 1'b0;
        bus.key_press  = 1'b0;
        bus.frame_tick = 1'b0;
        checks++;
        if ({bus.score_p1, bus.score_p2} !== 8'h00 || status() !== ST_RESET) begin
            errors++;
            $display("FAIL mid_point_reset: got %0d:%0d %b want 0:0 %b",
                     bus.score_p1, bus.score_p2, status(), ST_RESET);
        end
        @(negedge clk_0);
        checks++;
        if (status() !== ST_RESET) begin
            errors++;
            $display("FAIL reset_no_memory: got %b want %b", status(), ST_RESET);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(10);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(49);
        checks++;
        if (bus.ball_launch !== 1'b0 || bus.game_startup !== 1'b0 || bus.paddles_en !== 1'b1) begin
            errors++;
            $display("FAIL serve_key_no_restart: got launch=%b startup=%b paddles=%b want 0 0 1",
                     bus.ball_launch, bus.game_startup, bus.paddles_en);
        end
        ticks(1);
        checks++;
        if (status() !== LAUNCH_D1) begin
            errors++;
            $display("FAIL post_reset_launch: got %b want %b", status(), LAUNCH_D1);
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.key_press  = 1'b0;
        bus.p1_scored  = 1'b0;
        bus.p2_scored  = 1'b0;
        test_reset();
        test_serve_launch();
        test_p2_point();
        test_simultaneous();
        test_game_over();
        test_reset_mid_point();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
